wave_meter: RTL and testbench



---
 rtl/wave_meter_if.sv | 24 ++
 rtl/wave_meter.sv | 155 +++++++++++++++
 tb/tb_wave_meter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_meter_if.sv
// Signal bundle between a square-wave source/observer and the wave_meter.
interface wave_meter_if #(
  parameter int unsigned W = 8
);
  logic         en;
  logic         sig_in;
  logic [W-1:0] hi_count;
  logic [W-1:0] lo_count;
  logic         valid;
  logic         overflow;
  logic         busy;

  // Driver/observer side: controls enable and the waveform, reads results.
  modport master (
    output en, sig_in,
    input  hi_count, lo_count, valid, overflow, busy
  );

  // Meter side.
  modport slave (
    input  en, sig_in,
    output hi_count, lo_count, valid, overflow, busy
  );
endinterface

// File: rtl/wave_meter.sv
// wave_meter: measures the high and low durations of a square wave in
// prescaled ticks and publishes one (hi_count, lo_count) pair per period.
module wave_meter #(
  parameter int unsigned TICK_DIV = 5,
  parameter int unsigned W        = 8
) (
  input logic         clk,
  input logic         reset,
  wave_meter_if.slave bus
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [W-1:0]  CNT_MAX    = {W{1'b1}};

  typedef enum logic [1:0] {StIdle, StMeasHi, StMeasLo} state_e;

  logic meta_q, sync_q, prev_q;
  logic rise, fall;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic [W-1:0]  hi_tmp_q, hi_tmp_d;
  logic          sat_hi_q, sat_hi_d;
  logic [W-1:0]  hi_count_q, hi_count_d;
  logic [W-1:0]  lo_count_q, lo_count_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;

  logic          tick, cnt_full, phase_sat;
  logic [W-1:0]  phase_val;

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= bus.sig_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

  // A tick in the strobe cycle itself still counts, so the phase value is
  // floor(L / TICK_DIV) with the prescaler restarted on every strobe.
  assign tick      = (presc_q == PRESC_LAST);
  assign cnt_full  = (cnt_q == CNT_MAX);
  assign phase_val = cnt_full ? CNT_MAX : (cnt_q + {{(W-1){1'b0}}, tick});
  assign phase_sat = sat_q | (cnt_full & tick);

  // State, counters and published results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      hi_tmp_q   <= '0;
      sat_hi_q   <= 1'b0;
      hi_count_q <= '0;
      lo_count_q <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      hi_tmp_q   <= hi_tmp_d;
      sat_hi_q   <= sat_hi_d;
      hi_count_q <= hi_count_d;
      lo_count_q <= lo_count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state: run the phase counter, capture on fall, publish on rise.
  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : (presc_q + PRESC_ONE);
    cnt_d      = (tick && !cnt_full) ? (cnt_q + {{(W-1){1'b0}}, 1'b1}) : cnt_q;
    sat_d      = phase_sat;
    hi_tmp_d   = hi_tmp_q;
    sat_hi_d   = sat_hi_q;
    hi_count_d = hi_count_q;
    lo_count_d = lo_count_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        if (rise) begin
          state_d = StMeasHi;
        end
      end
      StMeasHi: begin
        if (fall) begin
          hi_tmp_d = phase_val;
          sat_hi_d = phase_sat;
          presc_d  = '0;
          cnt_d    = '0;
          sat_d    = 1'b0;
          state_d  = StMeasLo;
        end
      end
      StMeasLo: begin
        if (rise) begin
          hi_count_d = hi_tmp_q;
          lo_count_d = phase_val;
          overflow_d = sat_hi_q | phase_sat;
          valid_d    = 1'b1;
          sat_hi_d   = 1'b0;
          presc_d    = '0;
          cnt_d      = '0;
          sat_d      = 1'b0;
          state_d    = StMeasHi;
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable wins: drop any measurement in flight, keep the last results.
    if (!bus.en) begin
      state_d    = StIdle;
      presc_d    = '0;
      cnt_d      = '0;
      sat_d      = 1'b0;
      hi_tmp_d   = '0;
      sat_hi_d   = 1'b0;
      hi_count_d = hi_count_q;
      lo_count_d = lo_count_q;
      overflow_d = overflow_q;
      valid_d    = 1'b0;
    end
  end

  assign bus.hi_count = hi_count_q;
  assign bus.lo_count = lo_count_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: the stimulus model predicts each published
// pair when it drives the rise that completes a period.
module tb_wave_meter;

  localparam int unsigned TD   = 5;
  localparam int unsigned W    = 8;
  localparam int          MAXV = 255;

  logic clk;
  logic reset;

  wave_meter_if #(.W(W)) bus ();

  wave_meter #(.TICK_DIV(TD), .W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    int ovf;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  function automatic int ticks(input int len);
    int t;
    t = len / int'(TD);
    return (t > MAXV) ? MAXV : t;
  endfunction

  function automatic int sat(input int len);
    return ((len / int'(TD)) > MAXV) ? 1 : 0;
  endfunction

  // Model of what the meter has observed.
  logic cur     = 1'b0;
  int   cur_len = 0;
  int   hi_len  = 0;
  bit   armed   = 1'b0;
  bit   have_hi = 1'b0;

  // Drive sig_in to lvl (just after a posedge) and hold it for n cycles.
  task automatic seg(input logic lvl, input int n);
    bit pushed;
    exp_t e;
    pushed = 1'b0;
    if (lvl != cur) begin
      if (lvl) begin
        if (armed && have_hi) begin
          e.hi  = ticks(hi_len);
          e.lo  = ticks(cur_len);
          e.ovf = sat(hi_len) | sat(cur_len);
          e.cyc = cyc;
          exp_q.push_back(e);
          pushed = 1'b1;
        end
        armed   = 1'b1;
        have_hi = 1'b0;
      end else if (armed) begin
        hi_len  = cur_len;
        have_hi = 1'b1;
      end
      cur_len = 0;
    end
    bus.sig_in = lvl;
    cur        = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    cur_len += n;
    if (pushed && n >= 5) check("publish_pending", exp_q.size(), 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_hi_count", int'(bus.hi_count), 0);
    check("rst_lo_count", int'(bus.lo_count), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    armed   = 1'b0;
    have_hi = 1'b0;
  endtask

  // Drop enable for three cycles while holding the current level.
  task automatic en_drop(input int exp_hi, input int exp_lo);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("dis_busy", int'(bus.busy), 0);
    check("dis_hi_hold", int'(bus.hi_count), exp_hi);
    check("dis_lo_hold", int'(bus.lo_count), exp_lo);
    check("dis_valid", int'(bus.valid), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.en  = 1'b1;
    armed   = 1'b0;
    have_hi = 1'b0;
    cur_len += 3;
  endtask

  // Compare every published pair against the scoreboard.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi_count", int'(bus.hi_count), e.hi);
        check("lo_count", int'(bus.lo_count), e.lo);
        check("overflow", int'(bus.overflow), e.ovf);
        check("valid_latency", cyc - e.cyc, 3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en     = 1'b1;
    bus.sig_in = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_hi_count", int'(bus.hi_count), 0);
    check("init_lo_count", int'(bus.lo_count), 0);
    check("init_valid", int'(bus.valid), 0);
    check("init_overflow", int'(bus.overflow), 0);
    check("init_busy", int'(bus.busy), 0);
    reset = 1'b0;
    seg(1'b0, 10);
    check("idle_busy", int'(bus.busy), 0);

    // Basic 45/20 pattern.
    for (int i = 0; i < 4; i++) begin
      seg(1'b1, 45);
      if (i == 0) check("armed_busy", int'(bus.busy), 1);
      seg(1'b0, 20);
    end

    // Non-multiple durations, short low phase.
    seg(1'b1, 47);
    seg(1'b0, 24);
    seg(1'b1, 50);
    seg(1'b0, 4);

    // Saturating high phase, then recovery.
    seg(1'b1, 1300);
    seg(1'b0, 20);
    seg(1'b1, 45);
    seg(1'b0, 20);
    seg(1'b1, 45);
    seg(1'b0, 20);

    // One-cycle pulse inside a low phase.
    seg(1'b1, 45);
    seg(1'b0, 10);
    seg(1'b1, 1);
    seg(1'b0, 10);
    seg(1'b1, 45);
    seg(1'b0, 20);

    // Enable dropped during a high phase.
    seg(1'b1, 20);
    en_drop(9, 4);
    seg(1'b1, 22);
    seg(1'b0, 20);
    seg(1'b1, 45);
    seg(1'b0, 20);
    seg(1'b1, 45);
    seg(1'b0, 20);

    // Reset during a low phase, then rise/fall/rise.
    seg(1'b1, 45);
    seg(1'b0, 10);
    async_reset();
    seg(1'b0, 5);
    seg(1'b1, 45);
    seg(1'b0, 20);
    seg(1'b1, 45);
    seg(1'b0, 20);

    // Start high after reset, then a long static high phase.
    async_reset();
    seg(1'b0, 5);
    seg(1'b1, 30);
    check("first_rise_busy", int'(bus.busy), 1);
    seg(1'b0, 70);
    seg(1'b1, 5000);
    check("static_busy", int'(bus.busy), 1);
    seg(1'b0, 20);
    seg(1'b1, 10);
    seg(1'b0, 10);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
